// File: rtl/counter_seq_pkg.sv
// Shared constants for the counter sequencing controller.
//   - state_e : FSM encoding, also driven out on the 3-bit state port
//   - DEFAULT_TICK_DIV / DEFAULT_WIDTH : board defaults (50 MHz clock, 4-bit counter)
package counter_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 4;
  localparam int unsigned DEFAULT_TICK_DIV = 50_000_000;
  localparam int unsigned STATE_W          = 3;
  localparam int unsigned DISP_W           = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/counter_seq_ctrl_key_press_detect.sv
// Push-button press detector: 2-flop synchronizer followed by a previous-value
// flop; emits a one-cycle pulse on a synchronized 1->0 transition.
//   clk, rst_n : clock, async active-low reset (all flops clear to 0)
//   key_n      : raw active-low button
//   press_c    : combinational press pulse, valid for one cycle
module key_press_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_c
);

  logic sync1;
  logic sync2;
  logic prev;

  // Clearing to 0 means a key held low through reset release looks
  // already-pressed, so no pulse until a fresh release/press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press_c = prev & ~sync2;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an external loadable up/down counter.
// Debounced-free button handling (sync + edge detect), a run prescaler and a
// five-state FSM producing load/step strobes plus a display capture path.
//   clk, rst_n        : clock, async active-low reset
//   key_load_n        : raw active-low load button
//   key_run_n         : raw active-low run/pause button
//   mode_up           : direction request (1 up, 0 down)
//   d_in, limit       : preset value and terminal value
//   cnt_q             : counter value fed back from the datapath
//   cnt_load, cnt_en  : one-cycle load / step strobes
//   cnt_up            : direction to counter, frozen while running
//   disp_val, disp_upd: zero-extended counter snapshot and its update pulse
//   done, state       : DONE flag and current FSM encoding
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_load_n,
  input  logic               key_run_n,
  input  logic               mode_up,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [WIDTH-1:0]   limit,
  input  logic [WIDTH-1:0]   cnt_q,
  output logic               cnt_load,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic [DISP_W-1:0]  disp_val,
  output logic               disp_upd,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

  logic load_press_c;
  logic run_press_c;

  state_e               st_q,    st_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 strobe_q;
  logic                 load_d, en_d, up_d, done_d, upd_d;
  logic [DISP_W-1:0]    disp_d;
  logic                 tick_c;
  logic                 at_limit_c;

  // Button front ends
  key_press_detect u_key_load (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_load_n),
    .press_c (load_press_c)
  );

  key_press_detect u_key_run (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_run_n),
    .press_c (run_press_c)
  );

  assign tick_c     = (st_q == ST_RUN) && (presc_q == TICK_LAST);
  assign at_limit_c = (cnt_q == limit);

  // State, prescaler and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      presc_q  <= '0;
      strobe_q <= 1'b0;
      cnt_load <= 1'b0;
      cnt_en   <= 1'b0;
      cnt_up   <= 1'b0;
      done     <= 1'b0;
      disp_val <= '0;
      disp_upd <= 1'b0;
    end else begin
      st_q     <= st_d;
      presc_q  <= presc_d;
      strobe_q <= cnt_load | cnt_en;
      cnt_load <= load_d;
      cnt_en   <= en_d;
      cnt_up   <= up_d;
      done     <= done_d;
      disp_val <= disp_d;
      disp_upd <= upd_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    st_d    = st_q;
    presc_d = '0;
    load_d  = 1'b0;
    en_d    = 1'b0;
    up_d    = cnt_up;
    done_d  = 1'b0;
    disp_d  = disp_val;
    upd_d   = 1'b0;

    // Load beats run everywhere; a run press beats a terminal tick in RUN.
    case (st_q)
      ST_IDLE: begin
        if (load_press_c)     st_d = ST_LOAD;
        else if (run_press_c) st_d = ST_RUN;
      end
      ST_LOAD: st_d = ST_PAUSE;
      ST_RUN: begin
        if (load_press_c)              st_d = ST_LOAD;
        else if (run_press_c)          st_d = ST_PAUSE;
        else if (tick_c && at_limit_c) st_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (load_press_c)     st_d = ST_LOAD;
        else if (run_press_c) st_d = ST_RUN;
      end
      ST_DONE: begin
        if (load_press_c) st_d = ST_LOAD;
      end
      default: st_d = ST_IDLE;
    endcase

    // Prescaler only runs while staying in RUN, so every entry restarts at 0.
    if ((st_q == ST_RUN) && (st_d == ST_RUN)) begin
      presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
    end

    // A step is only issued when the sequence keeps running after the tick.
    en_d   = tick_c && !at_limit_c && (st_d == ST_RUN);
    load_d = (st_d == ST_LOAD);
    done_d = (st_d == ST_DONE);

    // Direction frozen for the whole RUN period.
    if (st_q != ST_RUN) begin
      up_d = mode_up;
    end

    // strobe_q marks the cycle in which the counter already holds its new value.
    if (strobe_q) begin
      disp_d = DISP_W'(cnt_q);
      upd_d  = 1'b1;
    end
  end

  assign state = STATE_W'(st_q);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam int W  = 4;
  localparam int TD = 4;

  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_PAUSE = 3, S_DONE = 4;
  localparam int K_LOAD = 0, K_EN = 1, K_UPD = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         key_load_n = 1'b1;
  logic         key_run_n = 1'b1;
  logic         mode_up = 1'b1;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] cnt_q = '0;
  logic         cnt_load, cnt_en, cnt_up, disp_upd, done;
  logic [7:0]   disp_val;
  logic [2:0]   state;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load_n (key_load_n),
    .key_run_n  (key_run_n),
    .mode_up    (mode_up),
    .d_in       (d_in),
    .limit      (limit),
    .cnt_q      (cnt_q),
    .cnt_load   (cnt_load),
    .cnt_en     (cnt_en),
    .cnt_up     (cnt_up),
    .disp_val   (disp_val),
    .disp_upd   (disp_upd),
    .done       (done),
    .state      (state)
  );

  // Loadable up/down counter datapath driven by the controller strobes
  always @(posedge clk) begin
    if (cnt_load)    cnt_q <= d_in;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end

  typedef struct {int kind; int cyc; int val;} ev_t;
  ev_t evq[$];

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int n_load = 0, n_en = 0, n_upd = 0;

  // Reference model state
  int m_st = 0, m_presc = 0, m_cnt = 0, m_disp = 0;
  bit m_up = 0, m_load = 0, m_en = 0, m_upd = 0, m_done = 0;
  bit hl[3] = '{0, 0, 0};
  bit hr[3] = '{0, 0, 0};
  int cap_q[$];

  // Behavioural reference: a key press acts on the 3rd edge after the fall,
  // i.e. when the sample two edges back is low and three edges back is high.
  always @(posedge clk) begin : model
    int  ns, old_cnt;
    bit  pl, pr, tick, at_lim, en_n, old_load, old_en, old_up, stay_run;
    cyc++;
    if (!rst_n) begin
      m_st = S_IDLE; m_presc = 0; m_disp = 0;
      m_up = 0; m_load = 0; m_en = 0; m_upd = 0; m_done = 0;
      hl = '{0, 0, 0}; hr = '{0, 0, 0};
      cap_q.delete();
    end else begin
      pl       = (hl[1] == 1'b0) && (hl[2] == 1'b1);
      pr       = (hr[1] == 1'b0) && (hr[2] == 1'b1);
      tick     = (m_st == S_RUN) && (m_presc == TD - 1);
      old_cnt  = m_cnt;
      at_lim   = (old_cnt == int'(limit));
      old_load = m_load; old_en = m_en; old_up = m_up;

      if (m_st == S_LOAD)                  ns = S_PAUSE;
      else if (pl)                         ns = S_LOAD;
      else if (pr && m_st != S_DONE)       ns = (m_st == S_RUN) ? S_PAUSE : S_RUN;
      else if (tick && at_lim)             ns = S_DONE;
      else                                 ns = m_st;

      stay_run = (m_st == S_RUN) && (ns == S_RUN);
      en_n     = tick && !at_lim && (ns == S_RUN);
      if (m_st != S_RUN) m_up = mode_up;

      m_upd = 0;
      if (cap_q.size() > 0 && cap_q[0] == cyc) begin
        void'(cap_q.pop_front());
        m_disp = old_cnt;
        m_upd  = 1;
      end

      if (old_load)    m_cnt = int'(d_in);
      else if (old_en) m_cnt = (old_cnt + (old_up ? 1 : 15)) % 16;

      m_load = (ns == S_LOAD);
      m_en   = en_n;
      m_done = (ns == S_DONE);
      if (m_load || m_en) cap_q.push_back(cyc + 2);

      if (m_load) evq.push_back('{K_LOAD, cyc, 0});
      if (m_en)   evq.push_back('{K_EN, cyc, int'(m_up)});
      if (m_upd)  evq.push_back('{K_UPD, cyc, m_disp});

      hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = key_load_n;
      hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = key_run_n;
      m_presc = stay_run ? (tick ? 0 : m_presc + 1) : 0;
      m_st = ns;
    end
  end

  task automatic chk_ev(input int k, input int v);
    ev_t e;
    n_cmp++;
    if (evq.size() == 0) begin
      n_bad++;
      $display("FAIL strobe_extra: got kind %0d val %0d at cycle %0d, expected no strobe", k, v, cyc);
    end else begin
      e = evq.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        n_bad++;
        $display("FAIL strobe: got kind %0d cyc %0d val %0d, expected kind %0d cyc %0d val %0d",
                 k, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, plus per-cycle status check
  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_load) begin n_load++; chk_ev(K_LOAD, 0); end
      if (cnt_en)   begin n_en++;   chk_ev(K_EN, int'(cnt_up)); end
      if (disp_upd) begin n_upd++;  chk_ev(K_UPD, int'(disp_val)); end
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL strobe_missing: got none at cycle %0d, expected kind %0d val %0d",
                 cyc, evq[0].kind, evq[0].val);
        void'(evq.pop_front());
      end
      n_cmp++;
      if (int'(state) != m_st || done != m_done || cnt_up != m_up || int'(disp_val) != m_disp) begin
        n_bad++;
        $display("FAIL status cyc %0d: got st=%0d done=%0d up=%0d disp=%0d, expected st=%0d done=%0d up=%0d disp=%0d",
                 cyc, state, done, cnt_up, disp_val, m_st, m_done, m_up, m_disp);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // which: bit0 load, bit1 run
  task automatic press(input int which, input int hold);
    if (which[0]) key_load_n = 1'b0;
    if (which[1]) key_run_n  = 1'b0;
    cyc_wait(hold);
    key_load_n = 1'b1;
    key_run_n  = 1'b1;
    cyc_wait(1);
  endtask

  task automatic wait_state(input int st, input int budget);
    int k = 0;
    while (int'(state) != st && k < budget) begin @(negedge clk); k++; end
    check("wait_state", int'(state), st);
    @(posedge clk); #3;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("reset_outputs",
          int'({cnt_load, cnt_en, cnt_up, disp_upd, done}) + int'(disp_val) + int'(state), 0);
    while (evq.size() > 0 && evq[$].cyc >= cyc) void'(evq.pop_back());
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  int b0, b1, b2;

  initial begin
    #1 rst_n = 1'b0;
    cyc_wait(3);
    rst_n = 1'b1;
    cyc_wait(3);

    // Mid-cycle asynchronous reset
    do_reset();
    cyc_wait(2);

    // Load d_in=3
    d_in = 4'd3; b0 = n_load; b1 = n_upd;
    press(1, 2);
    wait_state(S_PAUSE, 20);
    cyc_wait(4);
    check("load_state", int'(state), S_PAUSE);
    check("load_disp", int'(disp_val), 3);
    check("load_count", n_load - b0, 1);
    check("load_upd_count", n_upd - b1, 1);

    // Count up 3 -> 6
    limit = 4'd6; mode_up = 1'b1; b0 = n_en;
    press(2, 2);
    wait_state(S_DONE, 100);
    cyc_wait(3);
    check("up_en_count", n_en - b0, 3);
    check("up_disp", int'(disp_val), 6);
    check("up_done", int'(done), 1);

    // Down with wrap 1 -> 0 -> 15 -> 14
    mode_up = 1'b0; d_in = 4'd1; limit = 4'd14;
    press(1, 1);
    wait_state(S_PAUSE, 20);
    b0 = n_en;
    press(2, 1);
    wait_state(S_DONE, 100);
    cyc_wait(3);
    check("down_en_count", n_en - b0, 3);
    check("down_disp", int'(disp_val), 14);
    check("down_state", int'(state), S_DONE);

    // Simultaneous load + run while running
    mode_up = 1'b1; d_in = 4'd5; limit = 4'd2;
    press(1, 1);
    wait_state(S_PAUSE, 20);
    press(2, 1);
    wait_state(S_RUN, 20);
    cyc_wait(2);
    b0 = n_load;
    press(3, 1);
    wait_state(S_LOAD, 20);
    wait_state(S_PAUSE, 20);
    check("both_load_count", n_load - b0, 1);

    // Reset mid-RUN with run key held low through release
    press(2, 1);
    wait_state(S_RUN, 20);
    cyc_wait(1);
    key_run_n = 1'b0;
    do_reset();
    b0 = n_en;
    cyc_wait(20);
    check("held_key_no_en", n_en - b0, 0);
    check("held_key_idle", int'(state), S_IDLE);
    key_run_n = 1'b1;
    cyc_wait(3);
    press(2, 1);
    wait_state(S_RUN, 20);

    // Randomized phase
    for (int i = 0; i < 300; i++) begin
      b2 = $urandom_range(0, 9);
      case (b2)
        0, 1, 2: press(b2 + 1, $urandom_range(1, 3));
        3:       begin d_in = W'($urandom); cyc_wait(1); end
        4:       begin limit = W'($urandom); cyc_wait(1); end
        5:       begin mode_up = 1'($urandom); cyc_wait(1); end
        6, 8:    cyc_wait($urandom_range(1, 12));
        7:       if ($urandom_range(0, 5) == 0) do_reset(); else cyc_wait(2);
        default: press(2, 1);
      endcase
    end

    cyc_wait(10);
    check("queue_drained", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
